// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiply engine.
package mvm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS   = 3;
  localparam int DEF_COLS   = 3;
  localparam int DEF_OUT_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_X = 3'd2,
    MAC    = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Clamp v to the signed out_w range when sat is set; the caller keeps the low
  // out_w bits, so the unclamped path wraps in two's complement.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int out_w, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat && (v > hi)) sat_trunc = hi;
    else if (sat && (v < lo)) sat_trunc = lo;
    else sat_trunc = v;
  endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate lane; clr restarts the sum with the current product.
module mvm_mac
  import mvm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = 2 * DEF_DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= {ACC_W{1'b0}};
    end else if (en) begin
      acc <= (clr ? {ACC_W{1'b0}} : acc) + prod_ext;
    end
  end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply y = A*x over valid/ready streams with one MAC lane,
// matrix reuse across jobs and optional output saturation.
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ACC_W  = 2 * DATA_W + $clog2(COLS + 1),
  parameter int SAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    reuse_mtx,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    mtx_valid
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t state, state_nx;

  logic [AW-1:0] a_idx;
  logic [XW-1:0] c_idx;
  logic [YW-1:0] r_idx, wr_row, out_idx;
  logic          wr_pend, done;

  logic signed [DATA_W-1:0] a_mem [N];
  logic signed [DATA_W-1:0] x_mem [COLS];
  logic signed [OUT_W-1:0]  res   [ROWS];

  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] y_val;
  logic accept, reuse_hit, col_last, row_last;

  assign accept    = s_valid && s_ready;
  assign reuse_hit = reuse_mtx && mtx_valid;
  assign col_last  = (c_idx == XW'(COLS - 1));
  assign row_last  = (r_idx == YW'(ROWS - 1));
  assign y_val     = OUT_W'(sat_trunc({{(64 - ACC_W){acc[ACC_W-1]}}, acc}, OUT_W, SAT != 0));

  mvm_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    ((state == MAC) && !done),
    .clr   (c_idx == '0),
    .a     (a_mem[a_idx]),
    .b     (x_mem[c_idx]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reuse_hit) state_nx = (COLS == 1) ? MAC : LOAD_X;
          else           state_nx = (N == 1) ? LOAD_X : LOAD_A;
        end
      end
      LOAD_A:  if (accept && (a_idx == AW'(N - 1))) state_nx = LOAD_X;
      LOAD_X:  if (accept && col_last) state_nx = MAC;
      MAC:     if (done) state_nx = OUT;
      OUT:     if (m_ready && m_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The MAC state spends one extra "done" cycle so the last row sum lands in res
  // and m_valid rises ROWS*COLS+1 cycles after the final x beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      mtx_valid <= 1'b0;
      a_idx     <= '0;
      c_idx     <= '0;
      r_idx     <= '0;
      wr_row    <= '0;
      out_idx   <= '0;
      wr_pend   <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_ready <= (state_nx == IDLE) || (state_nx == LOAD_A) || (state_nx == LOAD_X);
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (reuse_hit) begin
              c_idx <= (COLS == 1) ? '0 : XW'(1);
            end else begin
              a_idx     <= (N == 1) ? '0 : AW'(1);
              mtx_valid <= (N == 1);
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (a_idx == AW'(N - 1)) begin
              a_idx     <= '0;
              mtx_valid <= 1'b1;
            end else begin
              a_idx <= a_idx + AW'(1);
            end
          end
        end
        LOAD_X: begin
          if (accept) c_idx <= col_last ? '0 : c_idx + XW'(1);
        end
        MAC: begin
          if (!done) begin
            wr_pend <= col_last;
            wr_row  <= r_idx;
            c_idx   <= col_last ? '0 : c_idx + XW'(1);
            if (col_last) r_idx <= row_last ? '0 : r_idx + YW'(1);
            a_idx   <= (col_last && row_last) ? '0 : a_idx + AW'(1);
            done    <= col_last && row_last;
          end else begin
            wr_pend <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b1;
            m_data  <= (ROWS == 1) ? y_val : res[0];
            m_last  <= (ROWS == 1);
            out_idx <= '0;
          end
        end
        OUT: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              out_idx <= out_idx + YW'(1);
              m_data  <= res[out_idx + YW'(1)];
              m_last  <= ((out_idx + YW'(1)) == YW'(ROWS - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and result storage carry no reset; contents are qualified by the FSM.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && accept) begin
      if (reuse_hit) x_mem[0] <= s_data;
      else           a_mem[0] <= s_data;
    end else if ((state == LOAD_A) && accept) begin
      a_mem[a_idx] <= s_data;
    end else if ((state == LOAD_X) && accept) begin
      x_mem[c_idx] <= s_data;
    end
    if (wr_pend) res[wr_row] <= y_val;
  end

endmodule

// File: tb/tb_mvm_engine.sv
// Directed bench for mvm_engine: default SAT=1, SAT=0 and a 2x4 4-bit instance.
module tb_mvm_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              sv[3], srdy[3], reuse[3], mv[3], mr[3], ml[3], bsy[3], mtxv[3];
  logic [7:0]        sd[3];
  logic signed [15:0] md[3];
  int acc_cnt[3] = '{0, 0, 0};
  int vectors = 0;
  int miscompares = 0;
  int q[$];
  int base;
  int lat;

  mvm_engine #(.SAT(1)) dut0 (
    .clk(clk), .reset(reset), .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]),
    .reuse_mtx(reuse[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
    .m_last(ml[0]), .busy(bsy[0]), .mtx_valid(mtxv[0]));

  mvm_engine #(.SAT(0)) dut1 (
    .clk(clk), .reset(reset), .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1]),
    .reuse_mtx(reuse[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
    .m_last(ml[1]), .busy(bsy[1]), .mtx_valid(mtxv[1]));

  mvm_engine #(.DATA_W(4), .ROWS(2), .COLS(4)) dut2 (
    .clk(clk), .reset(reset), .s_valid(sv[2]), .s_ready(srdy[2]), .s_data(sd[2][3:0]),
    .reuse_mtx(reuse[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
    .m_last(ml[2]), .busy(bsy[2]), .mtx_valid(mtxv[2]));

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (sv[i] && srdy[i]) acc_cnt[i] <= acc_cnt[i] + 1;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int sel, input int val, input logic ru);
    int k;
    sv[sel] = 1'b1;
    sd[sel] = 8'(val);
    reuse[sel] = ru;
    k = 0;
    while (!srdy[sel] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!srdy[sel]) check("accept_timeout", srdy[sel], 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gap(input int sel);
    sv[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_list(input int sel, input int vals[$], input logic ru_first,
                           input bit gaps);
    for (int i = 0; i < vals.size(); i++) begin
      send(sel, vals[i], (i == 0) ? ru_first : 1'b0);
      if (gaps) gap(sel);
    end
  endtask

  task automatic wait_valid(input int sel, output int k);
    k = 0;
    while (!mv[sel] && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic collect(input int sel, input int expq[$]);
    int k;
    mr[sel] = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      wait_valid(sel, k);
      check($sformatf("m_valid%0d_s%0d", i, sel), mv[sel], 1);
      check($sformatf("y%0d_s%0d", i, sel), md[sel], expq[i]);
      check($sformatf("m_last%0d_s%0d", i, sel), ml[sel], (i == expq.size() - 1) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_end", bsy[sel], 0);
    check("m_valid_end", mv[sel], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0; sd[i] = 8'd0; reuse[i] = 1'b0; mr[i] = 1'b1;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", srdy[0], 0);
    check("rst_m_valid", mv[0], 0);
    check("rst_m_data", md[0], 0);
    check("rst_m_last", ml[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_mtx_valid", mtxv[0], 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", srdy[0], 1);

    // Identity matrix, back-to-back beats, latency to first result
    q = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    send_list(0, q, 1'b0, 1'b0);
    check("mtx_valid_loaded", mtxv[0], 1);
    check("busy_loading", bsy[0], 1);
    q = '{5, -3, 7};
    send_list(0, q, 1'b0, 1'b0);
    sv[0] = 1'b0;
    wait_valid(0, lat);
    check("latency_3x3", lat, 10);
    q = '{5, -3, 7};
    collect(0, q);

    // Full load then a reuse job sending only x
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_list(0, q, 1'b0, 1'b0);
    q = '{1, 1, 1};
    send_list(0, q, 1'b0, 1'b0);
    sv[0] = 1'b0;
    q = '{6, 15, 24};
    collect(0, q);
    base = acc_cnt[0];
    q = '{1, 2, 3};
    send_list(0, q, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("no_accept_in_mac", srdy[0], 0);
    sv[0] = 1'b0;
    q = '{14, 32, 50};
    collect(0, q);
    check("reuse_beats", acc_cnt[0] - base, 3);

    // Gapped loading plus output backpressure
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_list(0, q, 1'b0, 1'b1);
    q = '{1, 1, 1};
    send_list(0, q, 1'b0, 1'b1);
    mr[0] = 1'b0;
    wait_valid(0, lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_m_valid", mv[0], 1);
      check("stall_m_data", md[0], 6);
      @(negedge clk);
    end
    q = '{6, 15, 24};
    collect(0, q);

    // Saturation: (-128*-128)*3 = 49152 clamps to 32767
    q = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    send_list(0, q, 1'b0, 1'b0);
    sv[0] = 1'b0;
    q = '{32767, 32767, 32767};
    collect(0, q);

    // Reset in the middle of MAC, then reuse request must fall back to a full load
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 1, 1};
    send_list(0, q, 1'b0, 1'b0);
    sv[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_s_ready", srdy[0], 0);
    check("midrst_m_valid", mv[0], 0);
    check("midrst_m_data", md[0], 0);
    check("midrst_m_last", ml[0], 0);
    check("midrst_busy", bsy[0], 0);
    check("midrst_mtx_valid", mtxv[0], 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = acc_cnt[0];
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3};
    send_list(0, q, 1'b1, 1'b0);
    sv[0] = 1'b0;
    q = '{14, 32, 50};
    collect(0, q);
    check("full_reload_beats", acc_cnt[0] - base, 12);
    check("mtx_valid_after_reload", mtxv[0], 1);

    // Truncation: 49152 wraps to -16384
    q = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    send_list(1, q, 1'b0, 1'b0);
    sv[1] = 1'b0;
    q = '{-16384, -16384, -16384};
    collect(1, q);

    // 2x4 matrix of 4-bit elements
    q = '{7, 7, 7, 7, -8, -8, -8};
    send_list(2, q, 1'b0, 1'b0);
    check("mtx_valid_before_last", mtxv[2], 0);
    send(2, -8, 1'b0);
    check("mtx_valid_after_8th", mtxv[2], 1);
    q = '{7, 7, 7, 7};
    send_list(2, q, 1'b0, 1'b0);
    sv[2] = 1'b0;
    wait_valid(2, lat);
    check("latency_2x4", lat, 9);
    q = '{196, -224};
    collect(2, q);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
